// File: rtl/data_mem.sv
`default_nettype none
// ============================================================================
// data_mem : word data memory with posted one-entry write buffer and
//            zero-fill init sweep after reset.                  rev 1.0
// ============================================================================
module data_mem #(
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH_LOG2 = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [WORD_WIDTH-1:0] mem_addr,
  input  logic [WORD_WIDTH-1:0] mem_wdata,
  output logic [WORD_WIDTH-1:0] mem_rdata,
  output logic                  mem_ready,
  output logic                  err_align,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  wr_count
);

  localparam logic [0:0]            ST_INIT    = 1'b0;
  localparam logic [0:0]            ST_IDLE    = 1'b1;
  localparam logic [DEPTH_LOG2-1:0] SWEEP_LAST = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = '1;

  logic [0:0]            state;
  logic [0:0]            state_nxt;
  logic [DEPTH_LOG2-1:0] sweep;
  logic                  idle;
  logic                  init_we;

  logic [WORD_WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic                  wb_valid;
  logic [DEPTH_LOG2-1:0] wb_idx;
  logic [WORD_WIDTH-1:0] wb_data;

  logic [DEPTH_LOG2-1:0] idx;
  logic                  addr_ok;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  bad_acc;

  assign idx     = mem_addr[DEPTH_LOG2+1:2];
  assign addr_ok = (mem_addr[1:0] == 2'b00) &&
                   (mem_addr[WORD_WIDTH-1:DEPTH_LOG2+2] == '0);
  assign rd_acc  = idle && mem_read  && addr_ok;
  assign wr_acc  = idle && mem_write && addr_ok;
  assign bad_acc = idle && (mem_read || mem_write) && !addr_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_INIT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (sweep == SWEEP_LAST) state_nxt = ST_IDLE;
      ST_IDLE: state_nxt = ST_IDLE;
      default: state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    idle      = (state == ST_IDLE);
    init_we   = (state == ST_INIT);
    mem_ready = (state == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         sweep <= '0;
    else if (init_we) sweep <= sweep + DEPTH_LOG2'(1);
  end

  // A new store displaces the previous entry, which drains on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid <= 1'b0;
      wb_idx   <= '0;
      wb_data  <= '0;
    end else if (wr_acc) begin
      wb_valid <= 1'b1;
      wb_idx   <= idx;
      wb_data  <= mem_wdata;
    end else begin
      wb_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (init_we)       mem[sweep]  <= '0;
    else if (wb_valid) mem[wb_idx] <= wb_data;
  end

  always_comb begin
    mem_rdata = '0;
    if (rd_acc) mem_rdata = (wb_valid && (wb_idx == idx)) ? wb_data : mem[idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_align <= 1'b0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      if (bad_acc) err_align <= 1'b1;
      if (rd_acc && (rd_count != CNT_MAX)) rd_count <= rd_count + CNT_WIDTH'(1);
      if (wr_acc && (wr_count != CNT_MAX)) wr_count <= wr_count + CNT_WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem.sv
`default_nettype none
// Randomized scoreboard bench for data_mem; a second instance with 4-bit
// counters shares the stimulus to exercise counter saturation.
module tb_data_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata, mem_rdata_s;
  logic        mem_ready, mem_ready_s, err_align, err_align_s;
  logic [15:0] rd_count, wr_count;
  logic [3:0]  rd_count_s, wr_count_s;

  always #5 clk = ~clk;

  data_mem dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .err_align(err_align),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  data_mem #(.CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata_s),
    .mem_ready(mem_ready_s), .err_align(err_align_s),
    .rd_count(rd_count_s), .wr_count(wr_count_s)
  );

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    bit          ready;
    bit          err;
    int          rc;
    int          wc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model: a plain word array where a store lands at the edge.
  logic [31:0] model_mem [256];
  int          init_edges;
  bit          m_err;
  int          m_rc, m_wc;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit addr_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < 32'h400);
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp, input int c);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, c, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("rdata",      mem_rdata,            e.rdata,                 e.cyc);
      chk("rdata_s",    mem_rdata_s,          e.rdata,                 e.cyc);
      chk("ready",      32'(mem_ready),       32'(e.ready),            e.cyc);
      chk("err_align",  32'(err_align),       32'(e.err),              e.cyc);
      chk("rd_count",   32'(rd_count),        32'(sat(e.rc, 65535)),   e.cyc);
      chk("wr_count",   32'(wr_count),        32'(sat(e.wc, 65535)),   e.cyc);
      chk("rd_count_s", 32'(rd_count_s),      32'(sat(e.rc, 15)),      e.cyc);
      chk("wr_count_s", 32'(wr_count_s),      32'(sat(e.wc, 15)),      e.cyc);
    end
  end

  // Drive one cycle just after a rising edge, predict, then advance the model.
  task automatic step(input bit rd, input bit wr, input logic [31:0] a,
                      input logic [31:0] d);
    exp_t e;
    bit   ok;
    ok        = addr_legal(a);
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = a;
    mem_wdata = d;
    e.cyc   = cyc;
    e.ready = (init_edges >= 256);
    e.rdata = (e.ready && rd && ok) ? model_mem[a[9:2]] : 32'h0;
    e.err   = m_err;
    e.rc    = m_rc;
    e.wc    = m_wc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    if (init_edges < 256) begin
      init_edges++;
    end else if (rd || wr) begin
      if (!ok) m_err = 1'b1;
      else begin
        if (rd) m_rc++;
        if (wr) begin
          m_wc++;
          model_mem[a[9:2]] = d;
        end
      end
    end
  endtask

  task automatic apply_reset();
    exp_t e;
    rst       = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    init_edges = 0;
    m_err = 1'b0;
    m_rc  = 0;
    m_wc  = 0;
    for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
    e.cyc = cyc; e.rdata = 32'h0; e.ready = 1'b0; e.err = 1'b0; e.rc = 0; e.wc = 0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc++;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    logic [7:0]  w;
    int          r;
    r = int'($urandom_range(0, 99));
    if (r < 80) w = 8'($urandom_range(0, 15));
    else        w = 8'($urandom_range(0, 255));
    a = {22'd0, w, 2'b00};
    r = int'($urandom_range(0, 99));
    if (r < 8)       a = a | 32'($urandom_range(1, 3));
    else if (r < 13) a = a | (32'h400 << $urandom_range(0, 21));
    return a;
  endfunction

  initial begin
    @(posedge clk);
    #1;
    apply_reset();
    repeat (256) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), $urandom);
    step(1, 0, 32'h3FC, 32'h0);

    // forwarding, then committed value
    step(0, 1, 32'h010, 32'hDEADBEEF);
    step(1, 0, 32'h010, 32'h0);
    step(0, 0, 32'h0, 32'h0);
    step(0, 0, 32'h0, 32'h0);
    step(1, 0, 32'h010, 32'h0);

    // back-to-back stores
    step(0, 1, 32'h020, 32'h11111111);
    step(0, 1, 32'h024, 32'h22222222);
    step(0, 1, 32'h020, 32'h33333333);
    step(1, 0, 32'h020, 32'h0);
    step(1, 0, 32'h024, 32'h0);

    // misaligned store, out-of-range load
    step(0, 1, 32'h012, 32'hCAFEF00D);
    step(1, 0, 32'h400, 32'h0);
    step(1, 0, 32'h010, 32'h0);

    // simultaneous load/store returns the pre-store value
    step(1, 1, 32'h024, 32'hA5A5A5A5);
    step(1, 0, 32'h024, 32'h0);

    repeat (20) step(1, 0, {22'd0, 8'($urandom_range(0, 255)), 2'b00}, 32'h0);

    repeat (1500) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), $urandom);

    // reset before the buffered store can drain
    step(0, 1, 32'h040, 32'h12345678);
    apply_reset();
    repeat (256) step(1, 0, 32'h040, 32'h0);
    step(1, 0, 32'h040, 32'h0);
    repeat (200) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), $urandom);
    step(0, 0, 32'h0, 32'h0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
